// File: rtl/reg_bank_writer_if.sv
// -----------------------------------------------------------------------------
// reg_bank_writer_if
// Write-request channel into the register bank: a valid/ready handshake that
// carries a 5-bit word index and a Q-bit data word.
//
// Signals:
//   wr_valid  master -> slave  write request present
//   wr_ready  slave  -> master bank can accept a write this cycle
//   wr_addr   master -> slave  destination word index 0..31
//   wr_data   master -> slave  Q-bit data to store
// -----------------------------------------------------------------------------
interface reg_bank_writer_if #(
  parameter int Q = 32
) ();
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [Q-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/reg_bank_writer.sv
// -----------------------------------------------------------------------------
// reg_bank_writer
// Write side of a 32-word register bank. Accepted writes update one word and
// pulse a one-hot write-enable for one cycle; a clear command sweeps the bank
// to zero one word per cycle while the write channel is held off.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (zeros the whole bank at once)
//   wr         write channel (reg_bank_writer_if.slave)
//   clr        single-cycle pulse, starts or restarts the clear sweep
//   busy       high while the clear sweep runs
//   we_onehot  registered one-hot index of the write accepted on the last edge
//   bank       all 32 words flattened, word k on bank[k*Q +: Q]
//
// Build option:
//   ZERO_REG_EN  when defined, word 0 is hard zero; writes to address 0 still
//                complete the handshake and pulse we_onehot[0] but are dropped.
// -----------------------------------------------------------------------------
module reg_bank_writer #(
  parameter int Q = 32
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_writer_if.slave  wr,
  input  logic              clr,
  output logic              busy,
  output logic [31:0]       we_onehot,
  output logic [32*Q-1:0]   bank
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic [4:0]   idx_r;
  logic [Q-1:0] word_r [32];
  logic [31:0]  we_onehot_r;
  logic         busy_s;
  logic         wr_ready_s;
  logic         accept_s;
  logic         store_s;

  // 5-bit index to 32-bit one-hot enable
  function automatic logic [31:0] onehot_decode(input logic [4:0] addr);
    onehot_decode = 32'd1 << addr;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clr always (re)enters CLEAR; the sweep ends after idx 31
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
        end else if (idx_r == 5'd31) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; ready depends only on state, clr and rst, never on wr_valid
  always_comb begin
    busy_s     = 1'b0;
    wr_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s     = 1'b0;
        wr_ready_s = ~clr & ~rst;
      end
      ST_CLEAR: begin
        busy_s     = 1'b1;
        wr_ready_s = 1'b0;
      end
      default: begin
        busy_s     = 1'b0;
        wr_ready_s = 1'b0;
      end
    endcase
  end

  assign accept_s    = wr.wr_valid & wr_ready_s;
  assign wr.wr_ready = wr_ready_s;
  assign busy        = busy_s;
  assign we_onehot   = we_onehot_r;

  // Decide whether an accepted write actually lands in storage
  always_comb begin
    store_s = 1'b0;
`ifdef ZERO_REG_EN
    if (accept_s && (wr.wr_addr != 5'd0)) begin
      store_s = 1'b1;
    end else begin
      store_s = 1'b0;
    end
`else
    if (accept_s) begin
      store_s = 1'b1;
    end else begin
      store_s = 1'b0;
    end
`endif
  end

  // Sweep index: clr restarts at 0, otherwise advances once per CLEAR cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= 5'd0;
    end else if (clr) begin
      idx_r <= 5'd0;
    end else if (state_r == ST_CLEAR) begin
      idx_r <= idx_r + 5'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Storage: reset zeros everything at once; the sweep clears word[idx]
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        word_r[k] <= {Q{1'b0}};
      end
    end else if (state_r == ST_CLEAR) begin
      word_r[idx_r] <= {Q{1'b0}};
    end else if (store_s) begin
      word_r[wr.wr_addr] <= wr.wr_data;
    end else begin
      word_r[0] <= word_r[0];
    end
  end

  // Write-enable pulse, high for exactly the cycle after an accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      we_onehot_r <= 32'd0;
    end else if (accept_s) begin
      we_onehot_r <= onehot_decode(wr.wr_addr);
    end else begin
      we_onehot_r <= 32'd0;
    end
  end

  // Flatten the words onto the read-side bus
  for (genvar g = 0; g < 32; g++) begin : g_bank
    assign bank[g*Q +: Q] = word_r[g];
  end

endmodule

// File: tb/tb_reg_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_writer
// Directed bench for reg_bank_writer. A behavioural bank model (array of words
// plus a sweep position) is checked against the DUT on every negative edge;
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_reg_bank_writer;
  localparam int Q = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            busy;
  logic [31:0]     we_onehot;
  logic [32*Q-1:0] bank;

  reg_bank_writer_if #(.Q(Q)) wr_if ();

  reg_bank_writer #(.Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr_if),
    .clr       (clr),
    .busy      (busy),
    .we_onehot (we_onehot),
    .bank      (bank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: stored words, sweep position (-1 when no sweep), enable pulse
  logic [Q-1:0] m_word [32];
  int           m_sweep = -1;
  logic [31:0]  m_onehot = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [Q-1:0] w(input int k);
    return bank[k*Q +: Q];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [Q-1:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  // Behavioural model updated on each active edge from the sampled inputs
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int k = 0; k < 32; k++) m_word[k] = '0;
      m_sweep  = -1;
      m_onehot = 32'd0;
    end else begin
      acc = (m_sweep < 0) && !clr && (wr_if.wr_valid === 1'b1);
      m_onehot = acc ? (32'd1 << wr_if.wr_addr) : 32'd0;
      if (m_sweep >= 0) m_word[m_sweep] = '0;
`ifdef ZERO_REG_EN
      if (acc && wr_if.wr_addr != 5'd0) m_word[wr_if.wr_addr] = wr_if.wr_data;
`else
      if (acc) m_word[wr_if.wr_addr] = wr_if.wr_data;
`endif
      if (clr) m_sweep = 0;
      else if (m_sweep == 31) m_sweep = -1;
      else if (m_sweep >= 0) m_sweep = m_sweep + 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 32; k++) begin
        check($sformatf("word%0d", k), w(k), m_word[k]);
      end
      check("we_onehot", we_onehot, m_onehot);
      check("busy", busy, (m_sweep >= 0));
      check("wr_ready", wr_if.wr_ready, (m_sweep < 0) && !clr && !rst);
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    clr = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 5'd0;
    wr_if.wr_data  = '0;
    step();
    check("rst_ready_low", wr_if.wr_ready, 1'b0);
    step();
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_onehot", we_onehot, 32'd0);
    check("rst_word5", w(5), 32'd0);
    check("rst_ready_high", wr_if.wr_ready, 1'b1);

    // Single write to word 5
    do_write(5'd5, 32'hDEADBEEF);
    check("t1_word5", w(5), 32'hDEADBEEF);
    check("t1_onehot", we_onehot, 32'h0000_0020);
    check("t1_word4", w(4), 32'd0);
    step();
    check("t1_onehot_off", we_onehot, 32'd0);

    // Back-to-back writes, last one wins
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 5'd31; wr_if.wr_data = 32'h1; step();
    check("t2_onehot31", we_onehot, 32'h8000_0000);
    wr_if.wr_addr = 5'd31; wr_if.wr_data = 32'h2; step();
    wr_if.wr_addr = 5'd0;  wr_if.wr_data = 32'h3; step();
    wr_if.wr_valid = 1'b0;
    check("t2_word31", w(31), 32'h2);
`ifdef ZERO_REG_EN
    check("t2_word0", w(0), 32'h0);
`else
    check("t2_word0", w(0), 32'h3);
`endif
    check("t2_onehot0", we_onehot, 32'h0000_0001);
    step();

    // Fill everything, then sweep
    for (int k = 0; k < 32; k++) do_write(k[4:0], 32'h100 + k);
    clr = 1'b1;
    step();
    clr = 1'b0;
`ifdef ZERO_REG_EN
    check("t3_word0_pre", w(0), 32'h0);
`else
    check("t3_word0_pre", w(0), 32'h100);
`endif
    check("t3_word31_pre", w(31), 32'h11F);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      step();
      if (cnt == 1) begin
        check("t3_word0_cleared", w(0), 32'h0);
        check("t3_word1_kept", w(1), 32'h101);
      end
    end
    check("t3_busy_len", cnt, 32);
    check("t3_ready_back", wr_if.wr_ready, 1'b1);
    check("t3_word31_end", w(31), 32'h0);

    // clr and write in the same IDLE cycle: write is refused
    do_write(5'd7, 32'h55);
    clr = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 5'd7; wr_if.wr_data = 32'hAA;
    #1;
    check("t4_ready_low", wr_if.wr_ready, 1'b0);
    step();
    clr = 1'b0;
    wr_if.wr_valid = 1'b0;
    check("t4_onehot", we_onehot, 32'd0);
    check("t4_word7_old", w(7), 32'h55);
    check("t4_busy", busy, 1'b1);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; step(); end
    check("t4_busy_len", cnt, 32);
    check("t4_word7_end", w(7), 32'h0);

    // Restart the sweep at idx 10 while a write is held pending
    do_write(5'd20, 32'h1234);
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 11) begin
        clr = 1'b1;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 5'd3; wr_if.wr_data = 32'h77;
      end
      step();
      clr = 1'b0;
      if (!busy) wr_if.wr_valid = 1'b0;
    end
    check("t5_busy_len", cnt, 43);
    check("t5_word3", w(3), 32'h0);
    check("t5_word20", w(20), 32'h0);

    // Reset in the middle of a sweep
    for (int k = 16; k < 32; k++) do_write(k[4:0], 32'h200 + k);
    do_write(5'd2, 32'h22);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (16) step();
    check("t6_busy_mid", busy, 1'b1);
    check("t6_word16_mid", w(16), 32'h210);
    check("t6_word2_mid", w(2), 32'h0);
    rst = 1'b1;
    step();
    for (int k = 0; k < 32; k++) check($sformatf("t6_word%0d", k), w(k), 32'h0);
    check("t6_busy", busy, 1'b0);
    check("t6_ready_in_rst", wr_if.wr_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", wr_if.wr_ready, 1'b1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
